// File: rtl/reg_scoreboard.sv
// reg_scoreboard: decode-stage hazard controller for a 32x32 register file.
// Counts in-flight writes per architectural register and refuses issue on a
// RAW hazard, on per-register or global counter saturation, or while the
// one-cycle FLUSH state is clearing the pending state.
//
// Optional feature (compile-time macro SCOREBOARD_WB_BYPASS_EN):
//   defined   - a source whose count is exactly 1 and which is being retired
//               this cycle does not cause a RAW stall. This relies on the
//               register file writing before it reads.
//   undefined - RAW decisions use pre-edge counts only.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   issue_valid         decoded instruction presented for issue
//   issue_rs/rt         source registers, qualified by issue_use_rs/rt
//   issue_dest/wr       destination register and its write enable
//   issue_stall         combinational issue refusal for this cycle
//   wb_valid/wb_reg     write-back committed to the register file
//   flush               discard all pending state
//   pending_mask        registered; bit i set when register i has pending writes
//   inflight            registered; total pending writes, saturating at 15
//   wb_error            sticky; write-back to a register with no pending write
module reg_scoreboard #(
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_use_rs,
  input  logic        issue_use_rt,
  input  logic [4:0]  issue_dest,
  input  logic        issue_wr,
  output logic        issue_stall,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic        flush,
  output logic [31:0] pending_mask,
  output logic [3:0]  inflight,
  output logic        wb_error
);

  localparam int unsigned NREG  = 32;
  localparam int unsigned TOT_W = (MAX_INFLIGHT < 2) ? 1 : $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [TOT_W-1:0] tot_q, tot_d;
  logic             err_d;
  logic [31:0]      mask_d;
  logic [3:0]       inflight_d;

  logic rs_busy, rt_busy, raw, full;
  logic retire, inc, same_reg, dec, wb_bad;

  // Hazard detection and issue handshake, all from pre-edge state.
  always_comb begin
    retire  = wb_valid && (wb_reg != 5'd0) && (state_q == RUN);
    rs_busy = issue_use_rs && (issue_rs != 5'd0) && (cnt_q[issue_rs] != '0);
    rt_busy = issue_use_rt && (issue_rt != 5'd0) && (cnt_q[issue_rt] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // Last pending write lands this cycle; the register file forwards it.
    if (retire && (wb_reg == issue_rs) && (cnt_q[issue_rs] == CNT_W'(1))) rs_busy = 1'b0;
    if (retire && (wb_reg == issue_rt) && (cnt_q[issue_rt] == CNT_W'(1))) rt_busy = 1'b0;
`endif
    raw  = rs_busy || rt_busy;
    full = issue_wr && (issue_dest != 5'd0) &&
           ((cnt_q[issue_dest] == CNT_MAX) || (tot_q == TOT_W'(MAX_INFLIGHT)));
    issue_stall = issue_valid && (raw || full || (state_q != RUN));

    inc      = issue_valid && !issue_stall && issue_wr && (issue_dest != 5'd0);
    // Accept and retire on one register cancel; the write-back is legitimate.
    same_reg = inc && retire && (issue_dest == wb_reg);
    dec      = retire && !same_reg && (cnt_q[wb_reg] != '0);
    wb_bad   = retire && !same_reg && (cnt_q[wb_reg] == '0);
  end

  // Next-state for counters, total, error flag and FSM.
  always_comb begin
    state_d = state_q;
    tot_d   = tot_q;
    err_d   = wb_error || wb_bad;
    for (int i = 0; i < int'(NREG); i++) cnt_d[i] = cnt_q[i];

    case (state_q)
      FLUSH: begin
        for (int i = 0; i < int'(NREG); i++) cnt_d[i] = '0;
        tot_d   = '0;
        state_d = flush ? FLUSH : RUN;
      end
      default: begin
        if (inc && !same_reg) cnt_d[issue_dest] = cnt_q[issue_dest] + CNT_W'(1);
        if (dec)              cnt_d[wb_reg]     = cnt_q[wb_reg] - CNT_W'(1);
        case ({inc && !same_reg, dec})
          2'b10:   tot_d = tot_q + TOT_W'(1);
          2'b01:   tot_d = tot_q - TOT_W'(1);
          default: tot_d = tot_q;
        endcase
        if (flush) state_d = FLUSH;
      end
    endcase
    cnt_d[0] = '0;
  end

  // Observable summaries of the next counter state, registered below.
  always_comb begin
    mask_d = '0;
    for (int i = 1; i < int'(NREG); i++) mask_d[i] = (cnt_d[i] != '0);
    if (32'(tot_d) > 32'd15) inflight_d = 4'd15;
    else                     inflight_d = 4'(tot_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      tot_q        <= '0;
      wb_error     <= 1'b0;
      pending_mask <= '0;
      inflight     <= '0;
      for (int i = 0; i < int'(NREG); i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      tot_q        <= tot_d;
      wb_error     <= err_d;
      pending_mask <= mask_d;
      inflight     <= inflight_d;
      for (int i = 0; i < int'(NREG); i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (CNT_W=2, MAX_INFLIGHT=8).
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs, issue_rt, issue_dest;
  logic        issue_use_rs, issue_use_rt, issue_wr;
  logic        issue_stall;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        flush;
  logic [31:0] pending_mask;
  logic [3:0]  inflight;
  logic        wb_error;

  int n_checks = 0;
  int n_fail   = 0;

  reg_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_use_rs (issue_use_rs),
    .issue_use_rt (issue_use_rt),
    .issue_dest   (issue_dest),
    .issue_wr     (issue_wr),
    .issue_stall  (issue_stall),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .flush        (flush),
    .pending_mask (pending_mask),
    .inflight     (inflight),
    .wb_error     (wb_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_use_rs = 0; issue_use_rt = 0;
    issue_dest = 0; issue_wr = 0; wb_valid = 0; wb_reg = 0; flush = 0;
  endtask

  // Present a read of rs (and optionally a write of dest).
  task automatic issue(input logic [4:0] rs, input logic urs, input logic [4:0] dest, input logic wr);
    issue_valid = 1; issue_rs = rs; issue_use_rs = urs; issue_rt = 0; issue_use_rt = 0;
    issue_dest = dest; issue_wr = wr;
  endtask

  task automatic wb(input logic [4:0] r);
    wb_valid = 1; wb_reg = r;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  logic exp_bypass_stall;

  initial begin
`ifdef SCOREBOARD_WB_BYPASS_EN
    exp_bypass_stall = 1'b0;
`else
    exp_bypass_stall = 1'b1;
`endif
    // Reset with random activity on the inputs.
    rst_n = 0;
    idle();
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'($urandom); issue_rs = 5'($urandom); issue_rt = 5'($urandom);
      issue_use_rs = 1'($urandom); issue_use_rt = 1'($urandom);
      issue_dest = 5'($urandom); issue_wr = 1'($urandom);
      wb_valid = 1'($urandom); wb_reg = 5'($urandom); flush = 1'($urandom);
      tick();
    end
    check("rst_mask", pending_mask, 32'h0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_wb_error", 32'(wb_error), 32'd0);
    idle();
    rst_n = 1;
    issue(5'd3, 1, 5'd0, 0); issue_use_rt = 1; issue_rt = 5'd4;
    settle(); check("rst_no_hazard_stall", 32'(issue_stall), 32'd0);
    idle(); settle(); check("idle_stall", 32'(issue_stall), 32'd0);
    tick();

    // RAW on r5, cleared by write-back.
    issue(5'd0, 0, 5'd5, 1); settle(); check("iss5_stall", 32'(issue_stall), 32'd0);
    tick(); idle();
    check("iss5_mask", pending_mask, 32'h0000_0020);
    check("iss5_inflight", 32'(inflight), 32'd1);
    issue(5'd5, 1, 5'd0, 0); settle(); check("raw_rs5", 32'(issue_stall), 32'd1);
    issue_use_rs = 0; issue_rt = 5'd5; issue_use_rt = 1;
    settle(); check("raw_rt5", 32'(issue_stall), 32'd1);
    issue(5'd0, 1, 5'd0, 0); settle(); check("r0_read_nostall", 32'(issue_stall), 32'd0);
    issue(5'd5, 1, 5'd0, 0); wb(5'd5);
    settle(); check("wb_same_cycle_raw", 32'(issue_stall), 32'(exp_bypass_stall));
    tick(); idle();
    check("wb5_inflight", 32'(inflight), 32'd0);
    check("wb5_mask", pending_mask, 32'h0);
    issue(5'd5, 1, 5'd0, 0); settle(); check("after_wb5_stall", 32'(issue_stall), 32'd0);
    tick(); idle();

    // Per-register saturation on r7.
    for (int i = 0; i < 3; i++) begin
      issue(5'd0, 0, 5'd7, 1); settle(); check("iss7_stall", 32'(issue_stall), 32'd0);
      tick();
    end
    idle();
    check("r7x3_inflight", 32'(inflight), 32'd3);
    check("r7x3_mask", pending_mask, 32'h0000_0080);
    issue(5'd0, 0, 5'd7, 1); settle(); check("r7_full_stall", 32'(issue_stall), 32'd1);
    idle(); wb(5'd7); tick(); idle();
    check("r7_wb_inflight", 32'(inflight), 32'd2);
    issue(5'd0, 0, 5'd7, 1); wb(5'd7); settle(); check("r7_same_stall", 32'(issue_stall), 32'd0);
    tick(); idle();
    check("r7_same_inflight", 32'(inflight), 32'd2);
    check("r7_same_wb_error", 32'(wb_error), 32'd0);
    wb(5'd7); tick(); wb(5'd7); tick(); idle();
    check("r7_drain_inflight", 32'(inflight), 32'd0);
    check("r7_drain_mask", pending_mask, 32'h0);

    // Global saturation at MAX_INFLIGHT.
    for (int r = 1; r <= 8; r++) begin
      issue(5'd0, 0, 5'(r), 1); tick();
    end
    idle();
    check("glob8_inflight", 32'(inflight), 32'd8);
    check("glob8_mask", pending_mask, 32'h0000_01FE);
    issue(5'd0, 0, 5'd9, 1); settle(); check("glob_full_stall", 32'(issue_stall), 32'd1);
    wb(5'd1); settle(); check("glob_full_pre_edge", 32'(issue_stall), 32'd1);
    tick(); idle();
    check("glob_retire1_inflight", 32'(inflight), 32'd7);
    issue(5'd0, 0, 5'd9, 1); wb(5'd2); settle(); check("glob_diff_stall", 32'(issue_stall), 32'd0);
    tick(); idle();
    check("glob_diff_inflight", 32'(inflight), 32'd7);
    check("glob_diff_mask", pending_mask, 32'h0000_03F8);
    issue(5'd0, 0, 5'd0, 1); settle(); check("dest0_stall", 32'(issue_stall), 32'd0);
    tick(); idle();
    check("dest0_inflight", 32'(inflight), 32'd7);

    // Flush clears pending state; FLUSH stalls and ignores write-back.
    flush = 1; tick(); idle();
    issue(5'd0, 0, 5'd0, 0); wb(5'd12);
    settle(); check("flush_stall", 32'(issue_stall), 32'd1);
    tick(); idle();
    check("flush_mask", pending_mask, 32'h0);
    check("flush_inflight", 32'(inflight), 32'd0);
    check("flush_wb_ignored", 32'(wb_error), 32'd0);
    issue(5'd3, 1, 5'd0, 0); settle(); check("post_flush_stall", 32'(issue_stall), 32'd0);
    tick(); idle();

    // Sticky write-back error.
    wb(5'd0); tick(); idle();
    check("wb_r0_no_error", 32'(wb_error), 32'd0);
    wb(5'd12); tick(); idle();
    check("wb_r12_error", 32'(wb_error), 32'd1);
    flush = 1; tick();
    issue(5'd0, 0, 5'd0, 0); settle(); check("flush_hold_stall", 32'(issue_stall), 32'd1);
    tick(); flush = 0;
    settle(); check("flush_held_stall", 32'(issue_stall), 32'd1);
    tick();
    settle(); check("flush_exit_stall", 32'(issue_stall), 32'd0);
    idle();
    check("wb_error_sticky", 32'(wb_error), 32'd1);
    rst_n = 0; tick(); rst_n = 1;
    check("wb_error_reset", 32'(wb_error), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
